// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a multicycle RV32 core: fetch/decode/exec/mem/wb with a bounded mem_ack wait.
// Define MULTICYCLE_CTRL_MULDIV_EN to add the MULW state and the mul_start/mul_done handshake.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       EQ,
  input  logic       A_lt_B,
  input  logic       A_lt_UB,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_en,
  output logic       pc_en,
  output logic       rd_en,
  output logic [2:0] func,
  output logic [2:0] rd_sel,
  output logic [2:0] sx_size,
  output logic       sub_sra,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       pc_alu_sel,
  output logic       pc_next_sel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
`ifdef MULTICYCLE_CTRL_MULDIV_EN
  ,
  output logic       mul_start,
  input  logic       mul_done
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_MULW   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [TO_W-1:0] CNT_LIMIT = TO_W'(TIMEOUT - 1);

  logic [2:0]      state_d, state_q;
  logic [TO_W-1:0] cnt_d, cnt_q;
  logic            illegal_d, illegal_q;
  logic            timeout_d, timeout_q;
  logic            is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic            is_load, is_store, is_imm, is_op, is_fence, is_system;
  logic            is_mul, mul_legal, op_legal, rd_write, br_taken, at_limit;
  logic            unused_funct7;

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_imm    = (opcode == OPC_IMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_fence  = (opcode == OPC_FENCE);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_mul    = is_op & funct7[0];

`ifdef MULTICYCLE_CTRL_MULDIV_EN
  assign mul_legal = 1'b1;
`else
  assign mul_legal = 1'b0;
`endif

  assign op_legal = (is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                     is_imm | is_op | is_fence | is_system) & ~(is_mul & ~mul_legal);
  assign rd_write = is_lui | is_auipc | is_jal | is_jalr | is_load | is_imm | is_op;
  assign at_limit = (cnt_q == CNT_LIMIT);
  assign unused_funct7 = ^{funct7[6], funct7[4:1]};

  always_comb begin
    case (funct3)
      3'b000:  br_taken = EQ;
      3'b001:  br_taken = ~EQ;
      3'b100:  br_taken = A_lt_B;
      3'b101:  br_taken = ~A_lt_B;
      3'b110:  br_taken = A_lt_UB;
      3'b111:  br_taken = ~A_lt_UB;
      default: br_taken = 1'b0;
    endcase
  end

  // Datapath selects are pure decode; the FSM only gates the enables.
  assign func        = (is_op | is_imm) ? funct3 : 3'd0;
  assign sub_sra     = (is_op | (is_imm & (funct3[1:0] == 2'b01))) ? funct7[5] : 1'b0;
  assign alu_a_sel   = is_jal | is_auipc;
  assign alu_b_sel   = is_imm | is_load | is_store | is_jalr | is_lui | is_auipc | is_jal;
  assign pc_next_sel = is_jal | is_jalr;
  assign pc_alu_sel  = ~(is_auipc | (is_branch & br_taken));
  assign sx_size     = funct3;

  always_comb begin
    rd_sel = 3'd1;
    if (is_jal | is_jalr) rd_sel = 3'd0;
    else if (is_lui)      rd_sel = 3'd2;
    else if (is_load)     rd_sel = 3'd3;
    else if (is_mul)      rd_sel = 3'd4;
    else if (is_auipc)    rd_sel = 3'd5;
  end

`ifdef MULTICYCLE_CTRL_MULDIV_EN
  logic mul_start_d, mul_start_q;
  assign mul_start = mul_start_q;
`endif

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
      mul_start_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
      mul_start_q <= mul_start_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
    mul_start_d = 1'b0;
`endif
    case (state_q)
      S_FETCH, S_MEM: begin
        // An ack on the limit cycle still completes the transfer.
        if (mem_ack) begin
          state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
        end else if (at_limit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load | is_store) state_d = S_MEM;
        else if (is_mul)        state_d = S_MULW;
        else                    state_d = S_WB;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
        mul_start_d = is_mul & ~is_load & ~is_store;
`endif
      end
      S_MULW: begin
`ifdef MULTICYCLE_CTRL_MULDIV_EN
        if (mul_done) state_d = S_WB;
`else
        state_d = S_TRAP;
`endif
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
      cnt_d = '0;
    end else if (mem_req && !mem_ack) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    rd_en   = 1'b0;
    if (!reset_in) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_en   = mem_ack;
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
        end
        S_WB: begin
          pc_en = 1'b1;
          rd_en = rd_write;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction is expanded by a transaction-level reference
// into its expected cycle trace (states, strobes, flags) and compared cycle by cycle.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_MULW   = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [2:0] st;
    logic       ack;
    logic       md;
    logic       req;
    logic       we;
    logic       ir;
    logic       pc;
    logic       rd;
    logic       ms;
    logic       dp;
    logic       ill;
    logic       to;
  } cyc_t;

  typedef struct packed {
    logic [2:0] func;
    logic       sub;
    logic [2:0] rsel;
    logic       rchk;
    logic       a;
    logic       b;
    logic       bchk;
    logic       pcn;
    logic       pca;
    logic [2:0] sx;
  } dp_t;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       EQ = 1'b0;
  logic       A_lt_B = 1'b0;
  logic       A_lt_UB = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, ir_en, pc_en, rd_en;
  logic [2:0] func, rd_sel, sx_size, state;
  logic       sub_sra, alu_a_sel, alu_b_sel, pc_alu_sel, pc_next_sel;
  logic       illegal, timeout;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
  logic       mul_start;
  logic       mul_done = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset_in(reset_in),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .EQ(EQ), .A_lt_B(A_lt_B), .A_lt_UB(A_lt_UB), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_en(ir_en), .pc_en(pc_en), .rd_en(rd_en),
    .func(func), .rd_sel(rd_sel), .sx_size(sx_size), .sub_sra(sub_sra),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .pc_alu_sel(pc_alu_sel),
    .pc_next_sel(pc_next_sel), .state(state), .illegal(illegal), .timeout(timeout)
`ifdef MULTICYCLE_CTRL_MULDIV_EN
    , .mul_start(mul_start), .mul_done(mul_done)
`endif
  );

  int   n_checks = 0;
  int   n_pass = 0;
  cyc_t plan[$];
  logic m_ill = 1'b0;
  logic m_to = 1'b0;
  logic m_trap = 1'b0;
  dp_t  e_dp;
  logic [6:0] op_tab [13];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] op, input logic [6:0] f7);
    if (op == OPR && f7[0]) return MULDIV;
    return op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR, FENCE, SYSTEM};
  endfunction

  function automatic dp_t exp_dp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic eq, input logic lt, input logic ltu);
    dp_t  d;
    logic taken;
    d = '0;
    d.func = (op == OPR || op == OPIMM) ? f3 : 3'd0;
    d.sub  = (op == OPR || (op == OPIMM && (f3 == 3'd1 || f3 == 3'd5))) ? f7[5] : 1'b0;
    d.rchk = 1'b1;
    if (op == JAL || op == JALR)     d.rsel = 3'd0;
    else if (op == LUI)              d.rsel = 3'd2;
    else if (op == LOAD)             d.rsel = 3'd3;
    else if (op == AUIPC)            d.rsel = 3'd5;
    else if (op == OPR && f7[0])     d.rsel = 3'd4;
    else if (op == OPR || op == OPIMM) d.rsel = 3'd1;
    else                             d.rchk = 1'b0;
    d.a    = (op == JAL || op == AUIPC);
    d.bchk = !(op inside {BRANCH, FENCE, SYSTEM});
    d.b    = op inside {OPIMM, LOAD, STORE, JALR, LUI, AUIPC, JAL};
    d.pcn  = (op == JAL || op == JALR);
    case (f3)
      3'd0:    taken = eq;
      3'd1:    taken = !eq;
      3'd4:    taken = lt;
      3'd5:    taken = !lt;
      3'd6:    taken = ltu;
      3'd7:    taken = !ltu;
      default: taken = 1'b0;
    endcase
    d.pca = !(op == AUIPC || (op == BRANCH && taken));
    d.sx  = f3;
    return d;
  endfunction

  function automatic void add(input logic [2:0] st, input logic ack, input logic md,
                              input logic req, input logic we, input logic ir, input logic pc,
                              input logic rd, input logic ms, input logic dp);
    cyc_t c;
    c.st = st; c.ack = ack; c.md = md; c.req = req; c.we = we; c.ir = ir;
    c.pc = pc; c.rd = rd; c.ms = ms; c.dp = dp; c.ill = m_ill; c.to = m_to;
    plan.push_back(c);
  endfunction

  // A request granted after d idle cycles; returns 1 when the wait limit expires first.
  function automatic bit wait_phase(input logic [2:0] st, input int d, input logic we,
                                    input logic fetch);
    for (int k = 0; k < TO; k++) begin
      if (k == d) begin
        add(st, 1'b1, 1'b0, 1'b1, we, fetch, 1'b0, 1'b0, 1'b0, 1'b0);
        return 1'b0;
      end
      add(st, 1'b0, 1'b0, 1'b1, we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    return 1'b1;
  endfunction

  function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic eq, input logic lt, input logic ltu,
                                input int dfetch, input int dmem, input int dmul, input int ntrap);
    bit is_mul;
    bit wr;
    is_mul = (op == OPR) && f7[0];
    wr     = op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OPR};
    plan.delete();
    m_trap = 1'b0;
    e_dp = exp_dp(op, f3, f7, eq, lt, ltu);
    if (wait_phase(ST_FETCH, dfetch, 1'b0, 1'b1)) begin
      m_to = 1'b1; m_trap = 1'b1;
    end else begin
      add(ST_DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!legal(op, f7)) begin
        m_ill = 1'b1; m_trap = 1'b1;
      end else begin
        add(ST_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (op == LOAD || op == STORE) begin
          if (wait_phase(ST_MEM, dmem, op == STORE, 1'b0)) begin
            m_to = 1'b1; m_trap = 1'b1;
          end
        end else if (is_mul) begin
          for (int k = 0; k <= dmul; k++)
            add(ST_MULW, 1'b1, k == dmul, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, k == 0, 1'b0);
        end
        if (!m_trap) add(ST_WB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wr, 1'b0, 1'b0);
      end
    end
    if (m_trap) begin
      for (int k = 0; k < ntrap; k++)
        add(ST_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endfunction

  task automatic play();
    foreach (plan[i]) begin
      mem_ack = plan[i].ack;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
      mul_done = plan[i].md;
`endif
      @(negedge clk);
      chk("state", 32'(state), 32'(plan[i].st));
      chk("mem_req", 32'(mem_req), 32'(plan[i].req));
      chk("mem_we", 32'(mem_we), 32'(plan[i].we));
      chk("ir_en", 32'(ir_en), 32'(plan[i].ir));
      chk("pc_en", 32'(pc_en), 32'(plan[i].pc));
      chk("rd_en", 32'(rd_en), 32'(plan[i].rd));
      chk("illegal", 32'(illegal), 32'(plan[i].ill));
      chk("timeout", 32'(timeout), 32'(plan[i].to));
`ifdef MULTICYCLE_CTRL_MULDIV_EN
      chk("mul_start", 32'(mul_start), 32'(plan[i].ms));
`endif
      if (plan[i].dp) begin
        chk("func", 32'(func), 32'(e_dp.func));
        chk("sub_sra", 32'(sub_sra), 32'(e_dp.sub));
        if (e_dp.rchk) chk("rd_sel", 32'(rd_sel), 32'(e_dp.rsel));
        chk("alu_a_sel", 32'(alu_a_sel), 32'(e_dp.a));
        if (e_dp.bchk) chk("alu_b_sel", 32'(alu_b_sel), 32'(e_dp.b));
        chk("pc_next_sel", 32'(pc_next_sel), 32'(e_dp.pcn));
        chk("pc_alu_sel", 32'(pc_alu_sel), 32'(e_dp.pca));
        chk("sx_size", 32'(sx_size), 32'(e_dp.sx));
      end
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
    mul_done = 1'b0;
`endif
  endtask

  // Reset is checked before any clock edge so the asynchronous path is what is observed.
  task automatic do_reset();
    mem_ack  = 1'b1;
    reset_in = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'(ST_FETCH));
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ir_en", 32'(ir_en), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
`ifdef MULTICYCLE_CTRL_MULDIV_EN
    chk("rst_mul_start", 32'(mul_start), 32'd0);
`endif
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    reset_in = 1'b0;
    m_ill = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic eq, input logic lt, input logic ltu,
                     input int dfetch, input int dmem, input int dmul, input int ntrap);
    opcode = op; funct3 = f3; funct7 = f7; EQ = eq; A_lt_B = lt; A_lt_UB = ltu;
    build(op, f3, f7, eq, lt, ltu, dfetch, dmem, dmul, ntrap);
    play();
    if (m_trap) do_reset();
    $display("instr op=%b f3=%0d f7=%h fetch_wait=%0d mem_wait=%0d trap=%0d checks=%0d",
             op, f3, f7, dfetch, dmem, m_trap, n_checks);
  endtask

  initial begin
    logic [6:0] r_op;
    logic [6:0] r_f7;
    op_tab = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR, FENCE, SYSTEM,
               7'h7F, 7'h00};
    #2;
    do_reset();

    run(OPIMM, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);  // ADDI, immediate fetch ack
    run(LOAD,  3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1, 2, 0, 1);  // LW, MEM held 3 cycles
    run(STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, TO - 1, 0, 1);  // ack on the limit cycle
    run(BRANCH, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1);
    run(BRANCH, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 2, 0, 0, 1);
    run(BRANCH, 3'd6, 7'h00, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1);
    run(BRANCH, 3'd2, 7'h00, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1);
    run(AUIPC, 3'd3, 7'h11, 1'b0, 1'b0, 1'b0, TO - 1, 0, 0, 1);
    run(JAL,   3'd1, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(JALR,  3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(LUI,   3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(OPR,   3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(OPIMM, 3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(FENCE, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(SYSTEM, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);
    run(OPR,   3'd0, 7'h01, 1'b0, 1'b0, 1'b0, 0, 0, 5, 3);  // MUL
    run(OPIMM, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, TO, 0, 0, 5);  // fetch never acked
    run(7'h7F, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3);  // unsupported opcode
    run(LOAD,  3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, TO, 0, 2);  // MEM never acked

    // Reset in the middle of a MEM transfer, then a slow fetch that only fits a cleared counter.
    build(LOAD, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, TO, 0, 1);
    while (plan.size() > 5) void'(plan.pop_back());
    opcode = LOAD; funct3 = 3'd2; funct7 = 7'h00;
    play();
    do_reset();
    run(OPIMM, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, TO - 1, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      r_op = op_tab[$urandom_range(0, 12)];
      case ($urandom_range(0, 3))
        0:       r_f7 = 7'h00;
        1:       r_f7 = 7'h20;
        2:       r_f7 = 7'h01;
        default: r_f7 = 7'($urandom_range(0, 127));
      endcase
      run(r_op, 3'($urandom_range(0, 7)), r_f7,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
          int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
